// File: rtl/sd_emmc_cmd_serial_if.sv
// Command-layer <-> CMD serialiser bundle, including the pad-side CMD line signals.
// master: command controller / pad side; slave: sd_emmc_cmd_serial.
interface sd_emmc_cmd_serial_if;
  logic         start_i;
  logic [1:0]   setting_i;
  logic [39:0]  cmd_i;
  logic         go_idle_i;
  logic         cmd_dat_i;
  logic         cmd_out_o;
  logic         cmd_oe_o;
  logic [119:0] response_o;
  logic         crc_ok_o;
  logic         index_ok_o;
  logic         finish_o;

  modport master (
    output start_i, setting_i, cmd_i, go_idle_i, cmd_dat_i,
    input  cmd_out_o, cmd_oe_o, response_o, crc_ok_o, index_ok_o, finish_o
  );

  modport slave (
    input  start_i, setting_i, cmd_i, go_idle_i, cmd_dat_i,
    output cmd_out_o, cmd_oe_o, response_o, crc_ok_o, index_ok_o, finish_o
  );
endinterface

// File: rtl/sd_emmc_cmd_serial.sv
// eMMC CMD-line serialiser: sends cmd+CRC7+end bit, optionally receives and checks an R1/R3 or R2 response.
// Optional SD_CMD_NCR_TIMEOUT_EN: bounds the response start-bit wait to NCR_MAX clocks.
module sd_emmc_cmd_serial #(
  parameter int unsigned NCC_CYCLES = 8,
  parameter int unsigned NCR_MAX    = 64
) (
  input  logic                    sd_clk,
  input  logic                    rst,
  sd_emmc_cmd_serial_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, TX, NCC, TURN, WAIT_START, RX, FINISH} state_t;

  // cnt_q holds the current cycle number relative to the start_i cycle (TX/NCC/TURN/WAIT)
  // or the received bit number after the start bit (RX).
  localparam logic [7:0] NCC_LAST = 8'(47 + NCC_CYCLES);
  localparam logic [7:0] NCR_LAST = 8'(50 + NCR_MAX);

  if (NCC_CYCLES < 2 || NCC_CYCLES > 200 || NCR_MAX < 1 || NCR_MAX > 205) begin : g_bad_param
    $error("sd_emmc_cmd_serial: NCC_CYCLES/NCR_MAX out of range for 8-bit counter");
  end

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [39:0]    tx_sr_q, tx_sr_d;
  logic [5:0]     idx_q, idx_d;
  logic           expect_q, expect_d;
  logic           long_q, long_d;
  logic [6:0]     crc_q, crc_d;
  logic [126:0]   rx_sr_q, rx_sr_d;
  logic [127:0]   rx_sr_n;
  logic           cmd_out_q, cmd_out_d;
  logic           cmd_oe_q, cmd_oe_d;
  logic [119:0]   response_q, response_d;
  logic           crc_ok_q, crc_ok_d;
  logic           index_ok_q, index_ok_d;
  logic           finish_q, finish_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    idx_d      = idx_q;
    expect_d   = expect_q;
    long_d     = long_q;
    crc_d      = crc_q;
    rx_sr_d    = rx_sr_q;
    cmd_out_d  = cmd_out_q;
    cmd_oe_d   = cmd_oe_q;
    response_d = response_q;
    crc_ok_d   = crc_ok_q;
    index_ok_d = index_ok_q;
    finish_d   = 1'b0;
    rx_sr_n    = {rx_sr_q, bus.cmd_dat_i};

    if (bus.go_idle_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      cmd_oe_d  = 1'b0;
      cmd_out_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
          if (bus.start_i) begin
            state_d   = TX;
            cnt_d     = 8'd1;
            tx_sr_d   = {bus.cmd_i[38:0], 1'b0};
            idx_d     = bus.cmd_i[37:32];
            expect_d  = bus.setting_i[0];
            long_d    = bus.setting_i[1];
            crc_d     = '0;
            cmd_out_d = bus.cmd_i[39];
            cmd_oe_d  = 1'b1;
          end
        end

        TX: begin
          cnt_d = cnt_q + 8'd1;
          // CRC absorbs each frame bit as it leaves, then shifts out MSB first
          if (cnt_q <= 8'd40) crc_d = crc7_step(crc_q, cmd_out_q);
          else                crc_d = {crc_q[5:0], 1'b0};
          if (cnt_q < 8'd40) begin
            cmd_out_d = tx_sr_q[39];
            tx_sr_d   = {tx_sr_q[38:0], 1'b0};
          end else if (cnt_q < 8'd47) begin
            cmd_out_d = crc_d[6];
          end else if (cnt_q == 8'd47) begin
            cmd_out_d = 1'b1;
          end else begin
            cmd_out_d = 1'b1;
            cmd_oe_d  = 1'b0;
            state_d   = expect_q ? TURN : NCC;
          end
        end

        NCC: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q >= NCC_LAST) begin
            state_d    = FINISH;
            finish_d   = 1'b1;
            crc_ok_d   = 1'b1;
            index_ok_d = 1'b1;
          end
        end

        TURN: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q >= 8'd50) state_d = WAIT_START;
        end

        WAIT_START: begin
          if (!bus.cmd_dat_i) begin
            state_d = RX;
            cnt_d   = 8'd1;
            crc_d   = '0;
            rx_sr_d = '0;
          end
`ifdef SD_CMD_NCR_TIMEOUT_EN
          else if (cnt_q >= NCR_LAST) begin
            state_d    = FINISH;
            finish_d   = 1'b1;
            crc_ok_d   = 1'b0;
            index_ok_d = 1'b0;
            response_d = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`else
          else begin
            cnt_d = NCR_LAST;
          end
`endif
        end

        RX: begin
          cnt_d   = cnt_q + 8'd1;
          rx_sr_d = rx_sr_n[126:0];
          // short: bits 46..8 (start bit already folded in as zero); long: bits 127..8
          if (long_q ? (cnt_q >= 8'd8 && cnt_q <= 8'd127) : (cnt_q <= 8'd39))
            crc_d = crc7_step(crc_q, bus.cmd_dat_i);
          if (cnt_q == (long_q ? 8'd135 : 8'd47)) begin
            state_d  = FINISH;
            finish_d = 1'b1;
            crc_ok_d = (crc_q == rx_sr_n[7:1]);
            if (long_q) begin
              response_d = rx_sr_n[127:8];
              index_ok_d = 1'b1;
            end else begin
              response_d = {rx_sr_n[39:8], 88'd0};
              index_ok_d = (rx_sr_n[45:40] == idx_q);
            end
          end
        end

        FINISH: begin
          state_d   = IDLE;
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
        end

        default: begin
          state_d   = IDLE;
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      idx_q      <= '0;
      expect_q   <= 1'b0;
      long_q     <= 1'b0;
      crc_q      <= '0;
      rx_sr_q    <= '0;
      cmd_out_q  <= 1'b1;
      cmd_oe_q   <= 1'b0;
      response_q <= '0;
      crc_ok_q   <= 1'b0;
      index_ok_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
      idx_q      <= idx_d;
      expect_q   <= expect_d;
      long_q     <= long_d;
      crc_q      <= crc_d;
      rx_sr_q    <= rx_sr_d;
      cmd_out_q  <= cmd_out_d;
      cmd_oe_q   <= cmd_oe_d;
      response_q <= response_d;
      crc_ok_q   <= crc_ok_d;
      index_ok_q <= index_ok_d;
      finish_q   <= finish_d;
    end
  end

  assign bus.cmd_out_o  = cmd_out_q;
  assign bus.cmd_oe_o   = cmd_oe_q;
  assign bus.response_o = response_q;
  assign bus.crc_ok_o   = crc_ok_q;
  assign bus.index_ok_o = index_ok_q;
  assign bus.finish_o   = finish_q;

endmodule

// File: tb/tb_sd_emmc_cmd_serial.sv
// Self-checking bench for sd_emmc_cmd_serial: random and directed commands against a frame-level card/host model.
module tb_sd_emmc_cmd_serial;
  localparam int unsigned NCC = 8;
  localparam int unsigned NCR = 64;

  logic sd_clk = 1'b0;
  logic rst;
  sd_emmc_cmd_serial_if bus ();

  sd_emmc_cmd_serial #(.NCC_CYCLES(NCC), .NCR_MAX(NCR)) dut (
    .sd_clk (sd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sd_clk = ~sd_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [119:0] exp_resp;
  logic         exp_crc_ok;
  logic         exp_idx_ok;
  logic [47:0]  last_tx;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (polynomial long division)
  function automatic logic [6:0] crc7_div(input logic [119:0] msg, input int unsigned nbits);
    logic [126:0] v;
    v = 127'(msg) << 7;
    for (int i = int'(nbits) + 6; i >= 7; i--)
      if (v[i]) v = v ^ (127'(8'h89) << (i - 7));
    return v[6:0];
  endfunction

  task automatic run_txn(input logic [39:0] cmd, input logic [1:0] setting, input logic [119:0] payload,
                         input bit crc_bad, input bit idx_bad, input bit no_reply,
                         input int unsigned s_cyc, input int unsigned tail);
    logic [47:0]  exp_frame, tx_frame, oe_mask;
    logic [135:0] rsp;
    logic [39:0]  body;
    logic [5:0]   ridx;
    logic [6:0]   c;
    logic [119:0] r_resp;
    logic         r_crc, r_idx;
    int           len, exp_fin, fin_cyc, last, bi;
    int unsigned  fin_seen;

    exp_frame = {cmd, crc7_div({80'd0, cmd}, 40), 1'b1};
    rsp = '1; len = 0; fin_seen = 0; fin_cyc = -1;
    r_resp = '0; r_crc = 1'b0; r_idx = 1'b0;
    if (!setting[0]) begin
      exp_fin = 48 + NCC;
      exp_crc_ok = 1'b1;
      exp_idx_ok = 1'b1;
    end else if (no_reply) begin
`ifdef SD_CMD_NCR_TIMEOUT_EN
      exp_fin = 51 + NCR;
      exp_resp = '0;
      exp_crc_ok = 1'b0;
      exp_idx_ok = 1'b0;
`else
      exp_fin = -1;
`endif
    end else if (setting[1]) begin
      c = crc7_div(payload, 120) ^ (crc_bad ? 7'h01 : 7'h00);
      rsp = {2'b00, 6'h3F, payload, c, 1'b1};
      len = 136;
      exp_fin = int'(s_cyc) + 136;
      exp_resp = payload;
      exp_crc_ok = !crc_bad;
      exp_idx_ok = 1'b1;
    end else begin
      ridx = cmd[37:32] ^ (idx_bad ? 6'h03 : 6'h00);
      body = {2'b00, ridx, payload[31:0]};
      c = crc7_div({80'd0, body}, 40) ^ (crc_bad ? 7'h01 : 7'h00);
      rsp = 136'({body, c, 1'b1});
      len = 48;
      exp_fin = int'(s_cyc) + 48;
      exp_resp = {payload[31:0], 88'd0};
      exp_crc_ok = !crc_bad;
      exp_idx_ok = !idx_bad;
    end

    @(posedge sd_clk); #1;
    bus.cmd_i = cmd;
    bus.setting_i = setting;
    bus.start_i = 1'b1;
    bus.cmd_dat_i = 1'b1;
    last = (exp_fin < 0) ? 300 : exp_fin + int'(tail);
    for (int k = 1; k <= last; k++) begin
      @(posedge sd_clk); #1;
      // stray start mid-transfer must be ignored
      bus.start_i = (k == 30);
      if (k == 30) begin
        bus.cmd_i = ~cmd;
        bus.setting_i = 2'($urandom);
      end
      if (k <= 48) begin
        tx_frame[48-k] = bus.cmd_out_o;
        oe_mask[48-k] = bus.cmd_oe_o;
      end
      if (k == 49) check("oe_release", 128'(bus.cmd_oe_o), 128'(0));
      if (bus.finish_o) begin
        fin_seen++;
        if (fin_cyc < 0) begin
          fin_cyc = k;
          r_resp = bus.response_o;
          r_crc = bus.crc_ok_o;
          r_idx = bus.index_ok_o;
        end
      end
      bi = len - 1 - (k - int'(s_cyc));
      bus.cmd_dat_i = (len > 0 && k >= int'(s_cyc) && bi >= 0) ? rsp[bi] : 1'b1;
    end
    bus.start_i = 1'b0;
    last_tx = tx_frame;
    check("tx_frame", 128'(tx_frame), 128'(exp_frame));
    check("tx_oe", 128'(oe_mask), 128'({48{1'b1}}));
    if (exp_fin < 0) begin
      check("wait_no_finish", 128'(fin_seen), 128'(0));
      @(posedge sd_clk); #1; bus.go_idle_i = 1'b1;
      @(posedge sd_clk); #1; bus.go_idle_i = 1'b0;
      check("wait_abort_oe", 128'(bus.cmd_oe_o), 128'(0));
      check("wait_abort_resp", 128'(bus.response_o), 128'(exp_resp));
    end else begin
      check("finish_cycle", 128'(fin_cyc), 128'(exp_fin));
      check("finish_count", 128'(fin_seen), 128'(1));
      check("response", 128'(r_resp), 128'(exp_resp));
      check("crc_ok", 128'(r_crc), 128'(exp_crc_ok));
      check("index_ok", 128'(r_idx), 128'(exp_idx_ok));
    end
  endtask

  task automatic abort_txn(input logic [39:0] cmd, input bit same_cycle);
    int unsigned oe_hi, fin;
    oe_hi = 0; fin = 0;
    @(posedge sd_clk); #1;
    bus.cmd_i = cmd;
    bus.setting_i = 2'b01;
    bus.start_i = 1'b1;
    bus.go_idle_i = same_cycle;
    bus.cmd_dat_i = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge sd_clk); #1;
      bus.start_i = 1'b0;
      bus.go_idle_i = (!same_cycle && k == 20);
      if (!same_cycle && k == 20) check("abort_tx_active", 128'(bus.cmd_oe_o), 128'(1));
      if (same_cycle || k >= 21) oe_hi += 32'(bus.cmd_oe_o);
      fin += 32'(bus.finish_o);
    end
    bus.go_idle_i = 1'b0;
    check(same_cycle ? "goidle_start_oe" : "abort_oe", 128'(oe_hi), 128'(0));
    check("abort_finish", 128'(fin), 128'(0));
    check("abort_resp_hold", 128'(bus.response_o), 128'(exp_resp));
    check("abort_crc_hold", 128'(bus.crc_ok_o), 128'(exp_crc_ok));
  endtask

  initial begin
    logic [39:0]  rcmd;
    logic [119:0] rpay;
    logic [1:0]   rset;
    bus.start_i = 1'b0;
    bus.setting_i = 2'b00;
    bus.cmd_i = '0;
    bus.go_idle_i = 1'b0;
    bus.cmd_dat_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge sd_clk);
    #1;
    check("rst_cmd_out", 128'(bus.cmd_out_o), 128'(1));
    check("rst_cmd_oe", 128'(bus.cmd_oe_o), 128'(0));
    check("rst_response", 128'(bus.response_o), 128'(0));
    check("rst_crc_ok", 128'(bus.crc_ok_o), 128'(0));
    check("rst_index_ok", 128'(bus.index_ok_o), 128'(0));
    check("rst_finish", 128'(bus.finish_o), 128'(0));
    rst = 1'b0;
    exp_resp = '0; exp_crc_ok = 1'b0; exp_idx_ok = 1'b0;

    run_txn(40'h40_0000_0000, 2'b00, '0, 0, 0, 0, 0, 2);
    check("cmd0_line", 128'(last_tx), 128'(48'h40_0000_0000_95));
    run_txn(40'h51_0000_0000, 2'b01, 120'h0000_0900, 0, 0, 0, 53, 0);
    check("cmd17_line", 128'(last_tx), 128'(48'h51_0000_0000_55));
    run_txn(40'h51_0000_0000, 2'b01, 120'h0000_0900, 1, 0, 0, 51, 0);
    run_txn(40'h51_0000_0000, 2'b01, 120'h0000_0900, 0, 1, 0, 57, 1);
    run_txn(40'h42_0000_0000, 2'b11, 120'h15_0100_4D4D_4331_3647_0123_4567_89AB, 0, 0, 0, 55, 2);
    abort_txn(40'h51_1234_5678, 1'b0);
    abort_txn(40'h40_0000_0000, 1'b1);
    run_txn(40'h51_0000_0000, 2'b01, 120'h0, 0, 0, 1, 0, 2);
    run_txn(40'h42_0000_0000, 2'b11, 120'hDEAD_BEEF, 1, 0, 0, 52, 0);

    for (int n = 0; n < 14; n++) begin
      rcmd = {2'b01, 6'($urandom), 32'($urandom)};
      rpay = {32'($urandom), 32'($urandom), 32'($urandom), 24'($urandom)};
      rset = 2'($urandom);
      run_txn(rcmd, rset, rpay, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0,
              51 + $urandom_range(0, 8), $urandom_range(0, 2));
    end

    // asynchronous reset in the middle of TX
    @(posedge sd_clk); #1;
    bus.cmd_i = 40'h51_0000_0000; bus.setting_i = 2'b01; bus.start_i = 1'b1;
    repeat (10) begin @(posedge sd_clk); #1; bus.start_i = 1'b0; end
    #2 rst = 1'b1;
    #1;
    check("midrst_oe", 128'(bus.cmd_oe_o), 128'(0));
    check("midrst_out", 128'(bus.cmd_out_o), 128'(1));
    check("midrst_resp", 128'(bus.response_o), 128'(0));
    check("midrst_crc", 128'(bus.crc_ok_o), 128'(0));
    @(posedge sd_clk); #1 rst = 1'b0;
    exp_resp = '0; exp_crc_ok = 1'b0; exp_idx_ok = 1'b0;
    run_txn(40'h51_0000_0000, 2'b01, 120'h0000_0900, 0, 0, 0, 54, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
